// File: rtl/sdpram_pkg.sv
// Shared definitions for the simple dual-port RAM and the FIFO controller that masters it.
package sdpram_pkg;

    // Cycles from renb sampled to dvalb/doutb valid.
    localparam int RAM_RD_LATENCY = 3;

    localparam int DEFAULT_MEM_DEPTH = 16;

    // Address type for the default RAM depth.
    typedef logic [$clog2(DEFAULT_MEM_DEPTH)-1:0] ptr_t;

    // Index width for a given depth, never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sdpram_if.sv
// Connection bundle between an SDP RAM and its master: write port A, read port B.
interface sdpram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16
);
    localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic                  wena;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  renb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  dvalb;

    modport sdp_m (
        output wena, addra, dina, renb, addrb,
        input  doutb, dvalb
    );

    modport sdp_s (
        input  wena, addra, dina, renb, addrb,
        output doutb, dvalb
    );
endinterface

// File: rtl/sdpram_out_buf.sv
// Small synchronous FIFO holding RAM read results until the downstream consumer takes them.
// The head entry is read straight from the storage registers, so it is stable while not popped.
module sdpram_out_buf
    import sdpram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         pop,
    output logic                         valid,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int IDX_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  do_pop;

    // Non-power-of-two depth, so wrap explicitly.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign dout   = mem[rd_idx];

    // Storage, indices and occupancy; push is guaranteed room by the caller's credit check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            // NOTE: the entries are cleared on reset (not just the indices) so the head reads 0
            // out of reset; this is affordable only because the buffer is a handful of flops.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_idx] <= din;
                wr_idx      <= next_idx(wr_idx);
            end
            if (do_pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// Streaming FIFO controller mastering an SDP RAM: writes accepted words on port A, issues
// credit-limited reads on port B and re-times the returning data through a skid buffer.
module sdpram_fifo_ctrl
    import sdpram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int RD_LATENCY = RAM_RD_LATENCY,
    parameter int OUT_DEPTH  = RD_LATENCY + 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [DATA_WIDTH-1:0]                     s_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [DATA_WIDTH-1:0]                     m_data,
    output logic [$clog2(MEM_DEPTH+OUT_DEPTH+1)-1:0]  level,
    sdpram_if.sdp_m                                   ifp
);
    localparam int PTR_W = ptr_width(MEM_DEPTH);
    localparam int CNT_W = $clog2(MEM_DEPTH + 1);
    localparam int IF_W  = $clog2(RD_LATENCY + 1);
    localparam int OB_W  = $clog2(OUT_DEPTH + 1);
    localparam int CR_W  = OB_W + 1;
    localparam int LVL_W = $clog2(MEM_DEPTH + OUT_DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] ram_cnt;
    logic [CNT_W-1:0] ram_cnt_d;
    logic [IF_W-1:0]  inflight;
    logic [IF_W-1:0]  inflight_d;
    logic [OB_W-1:0]  ob_cnt;
    logic [CR_W-1:0]  credit_used;
    logic             wr_en;
    logic             rd_issue;
    logic             ret_push;

    // Write side: accept whenever the RAM has a free slot.
    assign s_ready   = (ram_cnt != CNT_W'(MEM_DEPTH));
    assign wr_en     = s_valid && s_ready;
    assign ifp.wena  = wr_en;
    assign ifp.addra = wr_ptr;
    assign ifp.dina  = s_data;

    // Read issue: every outstanding read already owns a buffer slot, so results always fit.
    assign credit_used = CR_W'(inflight) + CR_W'(ob_cnt);
    assign rd_issue    = (ram_cnt != '0) && (credit_used < CR_W'(OUT_DEPTH));
    assign ifp.renb    = rd_issue;
    assign ifp.addrb   = rd_ptr;

    // Returns with nothing outstanding are leftovers from before a reset and are dropped.
    assign ret_push = ifp.dvalb && (inflight != '0);

    assign level = LVL_W'(ram_cnt) + LVL_W'(inflight) + LVL_W'(ob_cnt);

    // Next-state of the RAM occupancy and in-flight counters.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        ram_cnt_d  = ram_cnt;
        inflight_d = inflight;
        case ({wr_en, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt + CNT_W'(1);
            2'b01:   ram_cnt_d = ram_cnt - CNT_W'(1);
            default: ram_cnt_d = ram_cnt;
        endcase
        case ({rd_issue, ret_push})
            2'b10:   inflight_d = inflight + IF_W'(1);
            2'b01:   inflight_d = inflight - IF_W'(1);
            default: inflight_d = inflight;
        endcase
    end

    // Pointer and counter registers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            ram_cnt  <= ram_cnt_d;
            inflight <= inflight_d;
        end
    end

    sdpram_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH)
    ) u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_push),
        .din   (ifp.doutb),
        .pop   (m_ready),
        .valid (m_valid),
        .dout  (m_data),
        .count (ob_cnt)
    );

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Directed bench for sdpram_fifo_ctrl with a behavioural 3-cycle SDP RAM attached.
module tb_sdpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [4:0] level;

    int tests = 0;
    int fails = 0;

    sdpram_if #(.DATA_WIDTH(8), .MEM_DEPTH(16)) ifp ();

    sdpram_fifo_ctrl #(
        .DATA_WIDTH (8),
        .MEM_DEPTH  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level),
        .ifp     (ifp)
    );

    always #5 clk = ~clk;

    // RAM model: three register stages from renb sampled to dvalb; not reset, so it can
    // hold stale reads across a controller reset. inj forces spurious return pulses.
    logic [7:0] mem [16];
    logic       p1_v = 1'b0, p2_v = 1'b0, dv_r = 1'b0;
    logic [7:0] p1_d = '0, p2_d = '0, dout_r = '0;
    logic       inj = 1'b0;

    always @(posedge clk) begin
        if (ifp.wena) mem[ifp.addra] <= ifp.dina;
        p1_v   <= ifp.renb;
        p1_d   <= mem[ifp.addrb];
        p2_v   <= p1_v;
        p2_d   <= p1_d;
        dv_r   <= p2_v;
        dout_r <= p2_d;
    end

    assign ifp.dvalb = dv_r | inj;
    assign ifp.doutb = inj ? 8'hEE : dout_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   acc;
        int   got;
        int   sent;
        int   first_out;
        int   stalls;
        int   gaps;
        int   in_cnt;
        int   out_cnt;
        int   max_ob;
        logic hs_in;
        logic [7:0] q [$];
        logic [7:0] exp_d;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_renb", ifp.renb, 0);
        check("rst_addra", ifp.addra, 0);
        check("rst_addrb", ifp.addrb, 0);
        check("rst_level", level, 0);
        s_valid = 1'b1;
        s_data  = 8'h77;
        #1;
        check("rst_wena_follow", ifp.wena, 1);
        check("rst_dina_follow", ifp.dina, 8'h77);
        tick();
        check("rst_held_level", level, 0);
        check("rst_held_addra", ifp.addra, 0);
        s_valid = 1'b0;
        rst     = 1'b0;
        tick();

        // spurious returns with nothing outstanding must be dropped
        inj = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("spur_m_valid", m_valid, 0);
        end
        inj = 1'b0;
        tick();
        tick();
        check("spur_m_valid_after", m_valid, 0);
        check("spur_level", level, 0);

        // ---------------- single word latency ----------------
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();                                  // edge N: accepted
        s_valid = 1'b0;
        check("single_renb", ifp.renb, 1);
        check("single_level_n", level, 1);
        check("single_mv_n", m_valid, 0);
        tick();                                  // N+1: read sampled
        check("single_renb_off", ifp.renb, 0);
        tick();                                  // N+2
        tick();                                  // N+3: return valid
        check("single_dvalb", ifp.dvalb, 1);
        check("single_mv_n3", m_valid, 0);
        tick();                                  // N+4: captured
        check("single_mv_n4", m_valid, 1);
        check("single_data", m_data, 8'hA5);
        check("single_level_n4", level, 1);
        tick();                                  // N+5: popped
        check("single_mv_n5", m_valid, 0);
        check("single_level_end", level, 0);

        // ---------------- fill with downstream stalled ----------------
        m_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            s_valid = (acc < 33);
            s_data  = 8'(acc);
            hs_in   = s_valid && s_ready;
            tick();
            if (hs_in) acc++;
        end
        s_valid = 1'b0;
        check("fill_accepted", acc, 21);
        check("fill_s_ready", s_ready, 0);
        check("fill_level", level, 21);
        check("fill_m_valid", m_valid, 1);
        check("fill_head_stable", m_data, 8'h00);
        tick();
        check("fill_head_stable2", m_data, 8'h00);

        m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            if (m_valid) begin
                check("fill_order", m_data, 32'(got));
                got++;
            end
            tick();
        end
        check("fill_drained", got, 21);
        check("fill_level_end", level, 0);
        check("fill_s_ready_end", s_ready, 1);

        // ---------------- streaming at full rate ----------------
        sent = 0;
        got = 0;
        first_out = -1;
        stalls = 0;
        gaps = 0;
        for (int c = 0; c < 150; c++) begin
            s_valid = (sent < 100);
            s_data  = 8'(sent);
            if (s_valid && !s_ready) stalls++;
            hs_in = s_valid && s_ready;
            if (m_valid) begin
                check("stream_order", m_data, 32'(got));
                if (first_out < 0) first_out = c;
                got++;
            end else if (got > 0 && got < 100) begin
                gaps++;
            end
            tick();
            if (hs_in) sent++;
        end
        s_valid = 1'b0;
        check("stream_first_out", first_out, 5);
        check("stream_stalls", stalls, 0);
        check("stream_gaps", gaps, 0);
        check("stream_count", got, 100);
        check("stream_level_end", level, 0);

        // ---------------- random backpressure ----------------
        in_cnt = 0;
        out_cnt = 0;
        max_ob = 0;
        for (int c = 0; c < 20000 && out_cnt < 1000; c++) begin
            s_valid = (in_cnt < 1000) && ($urandom_range(0, 1) == 1);
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                in_cnt++;
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious", m_valid, 0);
                end else begin
                    exp_d = q.pop_front();
                    check("rand_order", m_data, exp_d);
                end
                out_cnt++;
            end
            if (int'(dut.ob_cnt) > max_ob) max_ob = int'(dut.ob_cnt);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("rand_delivered", out_cnt, 1000);
        check("rand_queue_empty", q.size(), 0);
        check("rand_ob_bound", (max_ob <= 5), 1);
        check("rand_level_end", level, 0);

        // ---------------- reset in mid-operation ----------------
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 8'h50 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        check("mrst_level_before", level, 6);
        rst = 1'b1;
        #1;
        check("mrst_async_m_valid", m_valid, 0);
        check("mrst_async_level", level, 0);
        tick();
        rst = 1'b0;
        check("mrst_m_valid", m_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_stale_dropped", m_valid, 0);
        end
        check("mrst_level_idle", level, 0);

        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        tick();
        s_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_valid) begin
                check("mrst_data", m_data, 8'h3C);
                got++;
            end
            tick();
        end
        check("mrst_count", got, 1);
        check("mrst_level_end", level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdpram_fifo_ctrl.md
# sdpram_fifo_ctrl

Streaming FIFO controller that drives a simple dual-port RAM as the master side of `sdpram_if`. It accepts words on a valid/ready upstream port, writes them through RAM port A, and issues reads on port B. Each read result arrives after the RAM's fixed 3-cycle `renb`→`dvalb` latency. Results land in a small output skid buffer that presents them on a valid/ready downstream port in strict FIFO order.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must equal `ifp.DATA_WIDTH`.
- `MEM_DEPTH`, 16: RAM depth, power of two ≥ 2; must equal `ifp.MEM_DEPTH`.
- `RD_LATENCY`, 3: RAM read latency in cycles, from `renb` sampled to `dvalb`/`doutb` valid.
- `OUT_DEPTH`, `RD_LATENCY+2`: output buffer entries.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `s_valid`, in, 1: upstream word valid.
- `s_ready`, out, 1: upstream ready.
- `s_data`, in, `DATA_WIDTH`: upstream word.
- `m_valid`, out, 1: downstream word valid.
- `m_ready`, in, 1: downstream ready.
- `m_data`, out, `DATA_WIDTH`: downstream word.
- `level`, out, `$clog2(MEM_DEPTH+OUT_DEPTH+1)`: words accepted but not yet delivered.
- `ifp`, modport `sdpram_if.sdp_m`. The controller drives `wena`, `addra`, `dina`, `renb` and `addrb`, and consumes `doutb` and `dvalb`.

## Operation
- State is held in these registers:
  - `wr_ptr`, `rd_ptr`: `$clog2(MEM_DEPTH)` bits each; wrap from `MEM_DEPTH-1` to 0.
  - `ram_cnt`: 0..`MEM_DEPTH`.
  - `inflight`: 0..`RD_LATENCY`.
  - Output buffer count `ob_cnt`: 0..`OUT_DEPTH`.
- Write side:
  - `s_ready = (ram_cnt != MEM_DEPTH)`.
  - `wena = s_valid & s_ready`, `addra = wr_ptr`, `dina = s_data`.
  - On `wena`, `wr_ptr` increments.
- Read issue:
  - `renb = (ram_cnt != 0) & (inflight + ob_cnt < OUT_DEPTH)`, with `addrb = rd_ptr`.
  - On `renb`, `rd_ptr` increments and `inflight` increments.
  - Credit is computed from registered counts only, so the output buffer can never overflow.
- Return path:
  - When `dvalb` is high and `inflight != 0`, `doutb` is pushed into the output buffer and `inflight` decrements.
  - When `dvalb` is high and `inflight == 0`, the word is discarded. This covers stale RAM pipeline contents after reset.
- Downstream: `m_valid = (ob_cnt != 0)`, `m_data` = buffer head; pop on `m_valid & m_ready`.
- `ram_cnt` update: +1 on write only, −1 on issue only, unchanged when both occur in the same cycle.
- `inflight` and `ob_cnt` follow the same rule for simultaneous increment and decrement.
- `level = ram_cnt + inflight + ob_cnt`.
- Read-after-write safety: a word written at edge N is readable by a read issued in any cycle after edge N, because `ram_cnt` is registered. A slot freed by an issue may be rewritten from the next edge onward.
- Reset: all pointers, counters and buffer contents clear, and state stays cleared while `rst` is high. Reset values:
  - 1: `s_ready`.
  - 0: `m_valid`, `m_data`, `renb`, `addrb`, `addra`, `level`.
  - `wena` and `dina` follow `s_valid`/`s_data`, gated by `s_ready`.

## Timing
- A word accepted at edge N drives `renb` in cycle N..N+1 (sampled at N+1). `dvalb` is high after edge N+1+`RD_LATENCY`−1, i.e. N+3. The word is captured at N+4 and `m_valid` rises after edge N+4 (4-cycle pass-through at defaults).
- Sustained throughput is 1 word/cycle with `s_valid` and `m_ready` held high.
- Maximum accepted words with `m_ready` held low: `MEM_DEPTH+OUT_DEPTH` (21 at defaults).
- Downstream handshake rule: `m_data` is stable while `m_valid & !m_ready`.

## Structure
- Shared package `sdpram_pkg`: `RAM_RD_LATENCY = 3` constant and a `ptr_t` typedef helper for depth-derived widths; this package is shared with the RAM.
- Sub-module `sdpram_out_buf`: synchronous FIFO of `OUT_DEPTH` entries, push/pop/count, registered head output.
- Top-level holds pointers, counters, issue/credit logic and the `level` sum.

## Test plan
- Reset: release `rst` → `s_ready=1`, `m_valid=0`, `renb=0`, `level=0`; inject 3 spurious `dvalb` pulses → `m_valid` stays 0.
- Single word: push 0xA5 at edge N with `m_ready=1` → `renb` sampled N+1, `m_valid`=1 with `m_data=0xA5` after N+4, then `level=0`.
- Fill: `m_ready=0`, push 0x00..0x20 continuously → exactly 21 accepted, `s_ready` falls after word 0x14. Then set `m_ready=1` → 0x00..0x14 delivered in order and `level` returns to 0.
- Streaming: 100 incrementing words with `s_valid`/`m_ready` held high → after 4 cycles, `m_valid` stays high one word per cycle, in order; pointers wrap 6 times.
- Random backpressure: random `s_valid` and `m_ready` at 50%, 1000 words → scoreboard order exact, no loss or duplication, `ob_cnt ≤ OUT_DEPTH` assertion holds.
- Mid-operation reset: 6 words pending, `rst` pulsed for 1 cycle → `m_valid=0`, stale `dvalb` data dropped. A subsequent push of 0x3C is the only word delivered.
